// File: rtl/spi_req_arbiter.sv
// Shares one spi_module between NUM_REQ requesters. A round-robin pick in IDLE
// latches the winner's config/data, holds the config for SETUP_CYC cycles,
// starts the transfer, waits for completion or timeout, then acks the winner.
module spi_req_arbiter #(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned SETUP_CYC = 2,
    parameter int unsigned TIMEOUT   = 1024
) (
    input  logic                        i_sys_clk,
    input  logic                        i_sys_rst,
    input  logic [NUM_REQ-1:0]          i_req,
    input  logic [NUM_REQ*32-1:0]       i_cfg,
    input  logic [NUM_REQ*DATA_W-1:0]   i_wdata,
    output logic [NUM_REQ-1:0]          o_ack,
    output logic [DATA_W-1:0]           o_rdata,
    output logic                        o_err,
    output logic                        o_busy,
    output logic [((NUM_REQ > 1) ? $clog2(NUM_REQ) : 1)-1:0] o_grant_id,
    output logic [31:0]                 o_spi_cfg,
    output logic [DATA_W-1:0]           o_spi_wdata,
    output logic                        o_spi_trans_en,
    input  logic                        i_spi_irq,
    input  logic [DATA_W-1:0]           i_spi_rdata
);

    localparam int unsigned GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned CW = 4;
    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CONFIG,
        S_START,
        S_WAIT,
        S_RESP
    } state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       setup_q, setup_d;
    logic [TW-1:0]       wait_q, wait_d;
    logic [GW-1:0]       ptr_q, ptr_d;
    logic [GW-1:0]       grant_q, grant_d;
    logic [31:0]         cfg_q, cfg_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                err_q, err_d;
    logic                busy_q, busy_d;
    logic                trans_en_q, trans_en_d;
    logic [NUM_REQ-1:0]  ack_q, ack_d;

    logic [NUM_REQ-1:0]  rot_c;
    logic                win_found_c;
    logic [GW-1:0]       win_off_c;
    logic [GW:0]         win_sum_c;
    logic [GW-1:0]       win_idx_c;

    // Round-robin pick: rotate requests so the search pointer sits at bit 0,
    // take the lowest set bit, then map the offset back to a requester index.
    always_comb begin
        rot_c       = NUM_REQ'({i_req, i_req} >> ptr_q);
        win_found_c = 1'b0;
        win_off_c   = '0;
        for (int j = int'(NUM_REQ) - 1; j >= 0; j--) begin
            if (rot_c[j]) begin
                win_found_c = 1'b1;
                win_off_c   = GW'(j);
            end
        end
        win_sum_c = (GW+1)'(ptr_q) + (GW+1)'(win_off_c);
        win_idx_c = (win_sum_c >= (GW+1)'(NUM_REQ)) ?
                    GW'(win_sum_c - (GW+1)'(NUM_REQ)) : GW'(win_sum_c);
    end

    // Next-state and registered-output values for the transaction FSM.
    always_comb begin
        state_d    = state_q;
        setup_d    = setup_q;
        wait_d     = wait_q;
        ptr_d      = ptr_q;
        grant_d    = grant_q;
        cfg_d      = cfg_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        err_d      = err_q;
        trans_en_d = 1'b0;
        ack_d      = '0;

        case (state_q)
            S_IDLE: begin
                if (win_found_c) begin
                    state_d = S_CONFIG;
                    setup_d = CW'(SETUP_CYC);
                    grant_d = win_idx_c;
                    cfg_d   = i_cfg[int'(win_idx_c)*32 +: 32];
                    wdata_d = i_wdata[int'(win_idx_c)*DATA_W +: DATA_W];
                    ptr_d   = (win_idx_c == GW'(NUM_REQ - 1)) ? '0 : win_idx_c + GW'(1);
                end
            end
            S_CONFIG: begin
                if (setup_q <= CW'(1)) begin
                    state_d    = S_START;
                    setup_d    = '0;
                    trans_en_d = 1'b1;
                end else begin
                    setup_d = setup_q - CW'(1);
                end
            end
            S_START: begin
                state_d    = S_WAIT;
                wait_d     = '0;
                trans_en_d = 1'b1;
            end
            S_WAIT: begin
                // Completion beats a timeout landing in the same cycle.
                if (i_spi_irq) begin
                    state_d        = S_RESP;
                    rdata_d        = i_spi_rdata;
                    err_d          = 1'b0;
                    ack_d[grant_q] = 1'b1;
                end else if (wait_q == TW'(TIMEOUT - 1)) begin
                    state_d        = S_RESP;
                    err_d          = 1'b1;
                    ack_d[grant_q] = 1'b1;
                end else begin
                    wait_d     = wait_q + TW'(1);
                    trans_en_d = 1'b1;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge i_sys_clk) begin
        if (i_sys_rst) begin
            state_q    <= S_IDLE;
            setup_q    <= '0;
            wait_q     <= '0;
            ptr_q      <= '0;
            grant_q    <= '0;
            cfg_q      <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
            busy_q     <= 1'b0;
            trans_en_q <= 1'b0;
            ack_q      <= '0;
        end else begin
            state_q    <= state_d;
            setup_q    <= setup_d;
            wait_q     <= wait_d;
            ptr_q      <= ptr_d;
            grant_q    <= grant_d;
            cfg_q      <= cfg_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            err_q      <= err_d;
            busy_q     <= busy_d;
            trans_en_q <= trans_en_d;
            ack_q      <= ack_d;
        end
    end

    assign o_ack          = ack_q;
    assign o_rdata        = rdata_q;
    assign o_err          = err_q;
    assign o_busy         = busy_q;
    assign o_grant_id     = grant_q;
    assign o_spi_cfg      = cfg_q;
    assign o_spi_wdata    = wdata_q;
    assign o_spi_trans_en = trans_en_q;

endmodule

// File: tb/tb_spi_req_arbiter.sv
// Bench for spi_req_arbiter: a timeline model (grant edge, response edge) is
// compared every cycle, plus directed scenarios with literal expectations.
module tb_spi_req_arbiter;

    localparam int unsigned N = 4;
    localparam int unsigned DW = 8;
    localparam int unsigned S = 2;
    localparam int unsigned T = 1024;

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      req;
    logic [N*32-1:0]   cfg;
    logic [N*DW-1:0]   wdata;
    logic [N-1:0]      ack;
    logic [DW-1:0]     rdata;
    logic              err;
    logic              busy;
    logic [1:0]        gid;
    logic [31:0]       spi_cfg;
    logic [DW-1:0]     spi_wdata;
    logic              ten;
    logic              irq;
    logic [DW-1:0]     spi_rdata;

    int nvec = 0;
    int nmis = 0;

    spi_req_arbiter #(.NUM_REQ(N), .DATA_W(DW), .SETUP_CYC(S), .TIMEOUT(T)) dut (
        .i_sys_clk(clk), .i_sys_rst(rst), .i_req(req), .i_cfg(cfg), .i_wdata(wdata),
        .o_ack(ack), .o_rdata(rdata), .o_err(err), .o_busy(busy), .o_grant_id(gid),
        .o_spi_cfg(spi_cfg), .o_spi_wdata(spi_wdata), .o_spi_trans_en(ten),
        .i_spi_irq(irq), .i_spi_rdata(spi_rdata)
    );

    always #5 clk = ~clk;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Timeline model: a transaction is a grant edge mG and a response edge mR.
    int          e = 0;
    bit          mact = 0;
    int          mG = 0;
    int          mR = -100;
    int          mptr = 0;
    int          mgid = 0;
    logic [31:0] mcfg = '0;
    logic [DW-1:0] mwd = '0;
    logic [DW-1:0] mrd = '0;
    bit          merr = 0;
    bit          x_busy = 0;
    bit          x_ten = 0;
    logic [N-1:0] x_ack = '0;

    always @(posedge clk) begin
        e++;
        if (rst) begin
            mact = 0; mR = -100; mptr = 0; mgid = 0;
            mcfg = '0; mwd = '0; mrd = '0; merr = 0;
        end else if (mact && (e - 1) >= mG + int'(S) + 1 && irq) begin
            mact = 0; mR = e; merr = 0; mrd = spi_rdata;
        end else if (mact && e == mG + int'(S) + 1 + int'(T)) begin
            mact = 0; mR = e; merr = 1;
        end else if (!mact && mR != e - 1 && req != '0) begin
            for (int k = 0; k < int'(N); k++) begin
                int idx;
                idx = (mptr + k) % int'(N);
                if (!mact && req[idx]) begin
                    mact = 1; mG = e; mgid = idx;
                    mcfg = cfg[idx*32 +: 32];
                    mwd = wdata[idx*DW +: DW];
                    mptr = (idx + 1) % int'(N);
                end
            end
        end
        x_busy = mact || (mR == e);
        x_ack  = (mR == e) ? N'(1 << mgid) : '0;
        x_ten  = mact && (e >= mG + int'(S));
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        chk("ack", 32'(ack), 32'(x_ack));
        chk("busy", 32'(busy), 32'(x_busy));
        chk("trans_en", 32'(ten), 32'(x_ten));
        chk("grant_id", 32'(gid), 32'(mgid));
        chk("spi_cfg", spi_cfg, mcfg);
        chk("spi_wdata", 32'(spi_wdata), 32'(mwd));
        chk("rdata", 32'(rdata), 32'(mrd));
        chk("err", 32'(err), 32'(merr));
    end

    task automatic wait_busy(output int eg);
        eg = -1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (busy) begin eg = e; return; end
        end
        chk("wait_busy_timeout", 32'(0), 32'(1));
    endtask

    task automatic wait_ten(output int es);
        es = -1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (ten) begin es = e; return; end
        end
        chk("wait_trans_en_timeout", 32'(0), 32'(1));
    endtask

    task automatic wait_ack(input int budget, output int er, output logic [N-1:0] a);
        er = -1; a = '0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (ack != '0) begin er = e; a = ack; return; end
        end
        chk("wait_ack_timeout", 32'(0), 32'(1));
    endtask

    // Called from the START-cycle negedge: irq is seen in WAIT cycle n.
    task automatic irq_in_wait(input int n, input logic [DW-1:0] d);
        repeat (n) @(posedge clk);
        #1 irq = 1'b1; spi_rdata = d;
        @(posedge clk);
        #1 irq = 1'b0;
    endtask

    int eg, es, er;
    logic [N-1:0] a;
    int order [5] = '{0, 1, 2, 3, 0};

    initial begin
        rst = 1'b1; req = '0; irq = 1'b0; spi_rdata = '0;
        cfg = {32'h4444_0003, 32'h3333_0002, 32'hD610_8011, 32'h1111_0000};
        wdata = {8'h44, 8'h33, 8'hA5, 8'h11};
        repeat (2) @(negedge clk);
        chk("reset_busy", 32'(busy), 32'(0));
        chk("reset_spi_cfg", spi_cfg, 32'h0);
        rst = 1'b0;

        // Single request from requester 1, irq after 40 full WAIT cycles.
        @(negedge clk); req = 4'b0010;
        wait_busy(eg);
        chk("a_cfg", spi_cfg, 32'hD610_8011);
        chk("a_gid", 32'(gid), 32'd1);
        wait_ten(es);
        chk("a_setup_cycles", 32'(es - eg), 32'd2);
        req = '0;
        irq_in_wait(41, 8'h3C);
        wait_ack(10, er, a);
        chk("a_ack", 32'(a), 32'h2);
        chk("a_rdata", 32'(rdata), 32'h3C);
        chk("a_err", 32'(err), 32'd0);
        chk("a_latency", 32'(er - eg), 32'd44);

        // Minimum latency: ack lands in the (SETUP_CYC+3)th cycle of the grant.
        @(negedge clk); req = 4'b0001;
        wait_busy(eg);
        wait_ten(es);
        irq_in_wait(1, 8'h77);
        wait_ack(10, er, a);
        req = '0;
        chk("b_min_latency", 32'(er - eg), 32'd4);
        chk("b_ack", 32'(a), 32'h1);

        // All four held: round-robin order from a fresh pointer.
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0; req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            wait_ten(es);
            irq_in_wait(k + 1, DW'(8'h10 + k));
            wait_ack(10, er, a);
            chk("c_rr_ack", 32'(a), 32'(1 << order[k]));
        end
        req = '0;

        // No irq: timeout exactly TIMEOUT WAIT cycles after START.
        @(negedge clk); req = 4'b0001;
        wait_ten(es);
        wait_ack(1200, er, a);
        req = '0;
        chk("d_timeout_dist", 32'(er - es), 32'd1025);
        chk("d_err", 32'(err), 32'd1);
        chk("d_ack", 32'(a), 32'h1);
        @(negedge clk);
        chk("d_ten_low", 32'(ten), 32'd0);

        // irq coincides with timeout expiry: irq wins.
        @(negedge clk); req = 4'b0100;
        wait_ten(es);
        irq_in_wait(int'(T), 8'h5A);
        wait_ack(10, er, a);
        req = '0;
        chk("e_dist", 32'(er - es), 32'd1025);
        chk("e_err", 32'(err), 32'd0);
        chk("e_rdata", 32'(rdata), 32'h5A);

        // irq during CONFIG is ignored; transaction times out.
        @(negedge clk); req = 4'b0010;
        wait_busy(eg);
        irq = 1'b1; spi_rdata = 8'hFF;
        @(negedge clk); irq = 1'b0;
        wait_ack(1200, er, a);
        req = '0;
        chk("f_err", 32'(err), 32'd1);
        chk("f_rdata_held", 32'(rdata), 32'h5A);
        chk("f_ack", 32'(a), 32'h2);

        // Reset during WAIT aborts silently; next grant from reset pointer.
        @(negedge clk); req = 4'b0001;
        wait_ten(es);
        repeat (5) @(negedge clk);
        rst = 1'b1; req = '0;
        @(negedge clk);
        chk("g_busy", 32'(busy), 32'd0);
        chk("g_ten", 32'(ten), 32'd0);
        chk("g_ack", 32'(ack), 32'd0);
        chk("g_cfg", spi_cfg, 32'h0);
        rst = 1'b0; req = 4'b1000;
        wait_ten(es);
        irq_in_wait(2, 8'h99);
        wait_ack(10, er, a);
        req = '0;
        chk("g_ack3", 32'(a), 32'h8);
        chk("g_gid3", 32'(gid), 32'd3);
        repeat (3) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
